mod_n_updown_counter: RTL and testbench
=======================================

Name: mod_n_updown_counter

Overview:
- Parametrised modulo-N up/down counter; the next-generation replacement for the fixed 2-bit counters used as row/column/step index sequencers in the matrix multiplier datapath.
- Adds:
  - configurable width and modulus
  - direction control
  - synchronous clear and load
  - wrap or saturate mode
  - a cascadable terminal-count output
  - sticky status flags

Parameters:
WIDTH, 4, counter width in bits; must satisfy 2^WIDTH >= MODULUS
MODULUS, 10, count range 0..MODULUS-1; legal range 2..2^WIDTH
SATURATE, 0, 0 = wrap at range ends, 1 = hold at range ends

Ports:
clk  input  1  clock; all state updates on rising edge
mr  input  1  master reset, asynchronous, active-high
ce  input  1  count enable
up  input  1  direction: 1 = increment, 0 = decrement
clr  input  1  synchronous clear to 0
ld  input  1  synchronous load of ld_val
ld_val  input  WIDTH  load value
count  output  WIDTH  current count, registered
tc  output  1  terminal count, combinational
wrap_p  output  1  one-cycle pulse, registered
sat_hit  output  1  sticky saturation flag, registered
ld_err  output  1  sticky illegal-load flag, registered

Behaviour:
- Reset:
  - mr=1 asynchronously forces count=0, wrap_p=0, sat_hit=0, ld_err=0, independent of clk.
  - Deassertion takes effect at the next rising edge.
  - Reset mid-count aborts immediately; no pending pulse survives.
- Per-edge priority (highest first): clr > ld > ce. Exactly one action per edge.
- clr=1:
  - count <= 0, sat_hit <= 0, ld_err <= 0, wrap_p <= 0.
- ld=1 (clr=0):
  - ld_val < MODULUS: count <= ld_val.
  - ld_val >= MODULUS: count <= MODULUS-1 and ld_err <= 1.
  - wrap_p <= 0.
- ce=1, up=1 (clr=0, ld=0):
  - count < MODULUS-1: count <= count+1.
  - count == MODULUS-1, SATURATE=0: count <= 0, wrap_p <= 1.
  - count == MODULUS-1, SATURATE=1: count holds, sat_hit <= 1.
- ce=1, up=0 (clr=0, ld=0):
  - count > 0: count <= count-1.
  - count == 0, SATURATE=0: count <= MODULUS-1, wrap_p <= 1.
  - count == 0, SATURATE=1: count holds, sat_hit <= 1.
- ce=0 with no clr/ld: count holds, wrap_p <= 0.
- wrap_p is high for exactly the one cycle following each wrap edge.
  - Consecutive wraps (MODULUS=2, continuous ce) keep it high on every such cycle.
- tc = ce & ~clr & ~ld & ((up & count==MODULUS-1) | (~up & count==0)).
  - Combinational; intended to drive the ce of the next cascaded stage.
  - Asserted in both modes, including when SATURATE=1 and the count holds.
- Direction change takes effect on the same edge; there is no pipeline delay.
- sat_hit and ld_err clear only by mr or clr.
- Latency: count reflects any action one edge after it is sampled; count has no combinational path from inputs.
- Arithmetic: compare and increment/decrement at WIDTH bits. Intermediate results never exceed MODULUS-1, so no overflow of WIDTH is possible.
- count never holds a value >= MODULUS after any legal sequence.

Test Plan:
- Reset/wrap-up: mr pulse mid-cycle with count=7 -> count=0 immediately. Then ce=1, up=1 for 10 edges (defaults) -> count 1..9 then 0; wrap_p=1 only in the cycle after 9->0; tc=1 only while count=9.
- Wrap-down: ld_val=2 load, then ce=1, up=0 for 4 edges -> count 1, 0, 9, 8; wrap_p high one cycle after 0->9; tc=1 while count=0.
- Saturate (SATURATE=1, MODULUS=10): count up to 9, then 3 more ce edges -> count stays 9, sat_hit=1, wrap_p stays 0. Reverse direction -> 8, sat_hit still 1. clr -> count=0, sat_hit=0.
- Illegal load: ld_val=12 -> count=9, ld_err=1. Next ld_val=3 -> count=3, ld_err remains 1.
- Priority: clr=1, ld=1, ce=1 on the same edge -> count=0. ld=1, ce=1 with ld_val=5 -> count=5, no increment. tc=0 whenever clr or ld is asserted.
- Cascade (two instances, WIDTH=4, MODULUS=10; low tc drives high ce) -> 00..99 sequence over 100 edges, high digit increments only on low 9->0. Then MODULUS=2 continuous ce -> wrap_p high on every cycle after the first wrap.

Source files
------------

// File: rtl/mod_n_updown_counter_if.sv
// Control and status bundle for one modulo-N up/down counter stage.
interface mod_n_updown_counter_if #(
  parameter int WIDTH = 4
);
  logic             ce;
  logic             up;
  logic             clr;
  logic             ld;
  logic [WIDTH-1:0] ld_val;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             wrap_p;
  logic             sat_hit;
  logic             ld_err;

  modport master (
    output ce, up, clr, ld, ld_val,
    input  count, tc, wrap_p, sat_hit, ld_err
  );

  modport slave (
    input  ce, up, clr, ld, ld_val,
    output count, tc, wrap_p, sat_hit, ld_err
  );
endinterface

// File: rtl/mod_n_updown_counter.sv
// Modulo-N up/down counter with wrap/saturate mode, cascadable terminal
// count and sticky saturation / illegal-load status flags.
module mod_n_updown_counter #(
  parameter int WIDTH    = 4,
  parameter int MODULUS  = 10,
  parameter int SATURATE = 0
) (
  input  logic                   clk,
  input  logic                   mr,
  mod_n_updown_counter_if.slave  bus
);

  localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);

  logic [WIDTH-1:0] r_count;
  logic             r_wrap_p;
  logic             r_sat_hit;
  logic             r_ld_err;

  logic [WIDTH-1:0] w_count_nxt;
  logic             w_wrap_nxt;
  logic             w_sat_nxt;
  logic             w_err_nxt;
  logic             w_at_top;
  logic             w_at_bot;
  logic             w_at_end;
  logic             w_step;
  logic             w_ld_bad;

  // Only called away from the range ends, so the result stays below MODULUS.
  function automatic logic [WIDTH-1:0] f_step(input logic [WIDTH-1:0] c,
                                              input logic             up_dir);
    if (up_dir) return c + 1'b1;
    return c - 1'b1;
  endfunction

  function automatic logic [WIDTH-1:0] f_clamp_load(input logic [WIDTH-1:0] v);
    return ({1'b0, v} < MOD_EXT) ? v : MAX_CNT;
  endfunction

  assign w_at_top = (r_count == MAX_CNT);
  assign w_at_bot = (r_count == '0);
  assign w_at_end = bus.up ? w_at_top : w_at_bot;
  assign w_step   = bus.ce & ~bus.clr & ~bus.ld;
  assign w_ld_bad = ({1'b0, bus.ld_val} >= MOD_EXT);

  always_comb begin
    w_count_nxt = r_count;
    w_wrap_nxt  = 1'b0;
    w_sat_nxt   = r_sat_hit;
    w_err_nxt   = r_ld_err;
    if (bus.clr) begin
      w_count_nxt = '0;
      w_sat_nxt   = 1'b0;
      w_err_nxt   = 1'b0;
    end else if (bus.ld) begin
      w_count_nxt = f_clamp_load(bus.ld_val);
      if (w_ld_bad) w_err_nxt = 1'b1;
    end else if (bus.ce) begin
      if (!w_at_end) begin
        w_count_nxt = f_step(r_count, bus.up);
      end else if (SATURATE != 0) begin
        w_sat_nxt = 1'b1;
      end else begin
        w_count_nxt = bus.up ? '0 : MAX_CNT;
        w_wrap_nxt  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge mr) begin
    if (mr) begin
      r_count   <= '0;
      r_wrap_p  <= 1'b0;
      r_sat_hit <= 1'b0;
      r_ld_err  <= 1'b0;
    end else begin
      r_count   <= w_count_nxt;
      r_wrap_p  <= w_wrap_nxt;
      r_sat_hit <= w_sat_nxt;
      r_ld_err  <= w_err_nxt;
    end
  end

  // tc is asserted at a range end even in saturate mode, so a cascade still advances.
  assign bus.tc      = w_step & w_at_end;
  assign bus.count   = r_count;
  assign bus.wrap_p  = r_wrap_p;
  assign bus.sat_hit = r_sat_hit;
  assign bus.ld_err  = r_ld_err;

endmodule

// File: tb/tb_mod_n_updown_counter.sv
// Directed bench: table of vectors for the default counter plus hand-written
// sequences for saturate mode, mid-cycle reset, a two-digit cascade and MODULUS=2.
module tb_mod_n_updown_counter;

  logic clk;
  logic mr;

  mod_n_updown_counter_if #(.WIDTH(4)) if0 ();
  mod_n_updown_counter_if #(.WIDTH(4)) if1 ();
  mod_n_updown_counter_if #(.WIDTH(4)) ifl ();
  mod_n_updown_counter_if #(.WIDTH(4)) ifh ();
  mod_n_updown_counter_if #(.WIDTH(1)) if2 ();

  mod_n_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) u0 (.clk(clk), .mr(mr), .bus(if0));
  mod_n_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1)) u1 (.clk(clk), .mr(mr), .bus(if1));
  mod_n_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) ul (.clk(clk), .mr(mr), .bus(ifl));
  mod_n_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) uh (.clk(clk), .mr(mr), .bus(ifh));
  mod_n_updown_counter #(.WIDTH(1), .MODULUS(2),  .SATURATE(0)) u2 (.clk(clk), .mr(mr), .bus(if2));

  assign ifh.ce = ifl.tc;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       clr;
    logic       ld;
    logic       ce;
    logic       up;
    logic [3:0] ld_val;
    logic       exp_tc;
    logic [3:0] exp_count;
    logic       exp_wrap;
    logic       exp_err;
  } vec_t;

  vec_t tbl[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic c, input logic l, input logic e, input logic u,
                     input logic [3:0] v, input logic t, input logic [3:0] cnt,
                     input logic w, input logic er);
    vec_t r;
    r.clr = c; r.ld = l; r.ce = e; r.up = u; r.ld_val = v;
    r.exp_tc = t; r.exp_count = cnt; r.exp_wrap = w; r.exp_err = er;
    tbl.push_back(r);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic e2_cnt;

    // fields: clr ld ce up ld_val | tc before edge, count, wrap_p, ld_err after edge
    for (int k = 1; k <= 9; k++) add(0, 0, 1, 1, 4'd0, 0, 4'(k), 0, 0);
    add(0, 0, 1, 1, 4'd0,  1, 4'd0, 1, 0);
    add(0, 0, 0, 1, 4'd0,  0, 4'd0, 0, 0);
    add(0, 1, 0, 0, 4'd2,  0, 4'd2, 0, 0);
    add(0, 0, 1, 0, 4'd0,  0, 4'd1, 0, 0);
    add(0, 0, 1, 0, 4'd0,  0, 4'd0, 0, 0);
    add(0, 0, 1, 0, 4'd0,  1, 4'd9, 1, 0);
    add(0, 0, 1, 0, 4'd0,  0, 4'd8, 0, 0);
    add(0, 0, 1, 1, 4'd0,  0, 4'd9, 0, 0);
    add(0, 0, 1, 0, 4'd0,  0, 4'd8, 0, 0);
    add(0, 1, 0, 0, 4'd12, 0, 4'd9, 0, 1);
    add(0, 1, 0, 0, 4'd3,  0, 4'd3, 0, 1);
    add(0, 0, 1, 1, 4'd0,  0, 4'd4, 0, 1);
    add(1, 1, 1, 1, 4'd5,  0, 4'd0, 0, 0);
    add(0, 1, 1, 1, 4'd5,  0, 4'd5, 0, 0);
    add(0, 1, 0, 0, 4'd9,  0, 4'd9, 0, 0);
    add(0, 1, 1, 1, 4'd4,  0, 4'd4, 0, 0);
    add(0, 1, 0, 0, 4'd9,  0, 4'd9, 0, 0);
    add(1, 0, 1, 1, 4'd0,  0, 4'd0, 0, 0);
    add(0, 0, 1, 0, 4'd0,  1, 4'd9, 1, 0);
    add(1, 0, 1, 0, 4'd0,  0, 4'd0, 0, 0);
    add(0, 0, 1, 0, 4'd0,  1, 4'd9, 1, 0);
    add(0, 1, 1, 0, 4'd6,  0, 4'd6, 0, 0);

    mr = 1'b1;
    {if0.ce, if0.up, if0.clr, if0.ld} = '0; if0.ld_val = '0;
    {if1.ce, if1.up, if1.clr, if1.ld} = '0; if1.ld_val = '0;
    {ifl.ce, ifl.up, ifl.clr, ifl.ld} = '0; ifl.ld_val = '0;
    {ifh.up, ifh.clr, ifh.ld} = '0;         ifh.ld_val = '0;
    {if2.ce, if2.up, if2.clr, if2.ld} = '0; if2.ld_val = '0;
    tick(); tick();
    chk("reset count", if0.count, 0);
    chk("reset wrap_p", if0.wrap_p, 0);
    chk("reset sat_hit", if1.sat_hit, 0);
    chk("reset ld_err", if0.ld_err, 0);
    mr = 1'b0;

    // mid-cycle reset with count=7
    if0.ld = 1'b1; if0.ld_val = 4'd7;
    tick();
    chk("load 7", if0.count, 7);
    if0.ld = 1'b0;
    #3 mr = 1'b1;
    #1 chk("async reset count from 7", if0.count, 0);
    #1 mr = 1'b0;

    // mid-cycle reset clears a pending pulse and the sticky flag
    if0.ld = 1'b1; if0.ld_val = 4'd12;
    tick();
    if0.ld = 1'b0; if0.ce = 1'b1; if0.up = 1'b1;
    tick();
    chk("pre-reset wrap_p", if0.wrap_p, 1);
    chk("pre-reset ld_err", if0.ld_err, 1);
    if0.ce = 1'b0;
    #3 mr = 1'b1;
    #1;
    chk("async reset wrap_p", if0.wrap_p, 0);
    chk("async reset ld_err", if0.ld_err, 0);
    chk("async reset count", if0.count, 0);
    #1 mr = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      if0.clr = tbl[i].clr; if0.ld = tbl[i].ld; if0.ce = tbl[i].ce;
      if0.up = tbl[i].up; if0.ld_val = tbl[i].ld_val;
      #1 chk($sformatf("vec%0d tc", i), if0.tc, tbl[i].exp_tc);
      tick();
      chk($sformatf("vec%0d count", i), if0.count, tbl[i].exp_count);
      chk($sformatf("vec%0d wrap_p", i), if0.wrap_p, tbl[i].exp_wrap);
      chk($sformatf("vec%0d ld_err", i), if0.ld_err, tbl[i].exp_err);
      chk($sformatf("vec%0d sat_hit", i), if0.sat_hit, 0);
    end
    {if0.ce, if0.clr, if0.ld} = '0;

    // saturate mode
    if1.ce = 1'b1; if1.up = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      #1 chk($sformatf("sat up tc %0d", k), if1.tc, 0);
      tick();
      chk($sformatf("sat up count %0d", k), if1.count, k);
    end
    for (int k = 0; k < 3; k++) begin
      #1 chk($sformatf("sat hold tc %0d", k), if1.tc, 1);
      tick();
      chk($sformatf("sat hold count %0d", k), if1.count, 9);
      chk($sformatf("sat hold flag %0d", k), if1.sat_hit, 1);
      chk($sformatf("sat hold wrap_p %0d", k), if1.wrap_p, 0);
    end
    if1.up = 1'b0;
    tick();
    chk("sat reverse count", if1.count, 8);
    chk("sat reverse flag", if1.sat_hit, 1);
    if1.ce = 1'b0; if1.clr = 1'b1;
    tick();
    chk("sat clr count", if1.count, 0);
    chk("sat clr flag", if1.sat_hit, 0);
    if1.clr = 1'b0; if1.ce = 1'b1; if1.up = 1'b0;
    #1 chk("sat low tc", if1.tc, 1);
    tick();
    chk("sat low count", if1.count, 0);
    chk("sat low flag", if1.sat_hit, 1);
    chk("sat low wrap_p", if1.wrap_p, 0);
    if1.ce = 1'b0;

    // two-digit cascade
    ifl.ce = 1'b1; ifl.up = 1'b1; ifh.up = 1'b1;
    for (int e = 1; e <= 100; e++) begin
      tick();
      chk($sformatf("cascade edge %0d", e), ifh.count * 10 + ifl.count, e % 100);
    end
    ifl.ce = 1'b0;

    // MODULUS=2: direction steered so that every edge after the first wraps
    e2_cnt = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if2.ce = 1'b1;
      if2.up = (i == 0) ? 1'b1 : e2_cnt;
      #1 chk($sformatf("mod2 tc %0d", i), if2.tc, (i != 0));
      tick();
      e2_cnt = ~e2_cnt;
      chk($sformatf("mod2 count %0d", i), if2.count, e2_cnt);
      chk($sformatf("mod2 wrap_p %0d", i), if2.wrap_p, (i != 0));
    end
    if2.ce = 1'b0;
    tick();
    chk("mod2 idle wrap_p", if2.wrap_p, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
